// File: rtl/uart_apb_pkg.sv
// Shared definitions for the multi-channel UART APB front-end.
// Register offsets, register bit positions, the access FSM state type and
// the parity mode encoding.
package uart_apb_pkg;

    localparam logic [4:0] OFF_TXDATA   = 5'h00;
    localparam logic [4:0] OFF_RXDATA   = 5'h04;
    localparam logic [4:0] OFF_STATUS   = 5'h08;
    localparam logic [4:0] OFF_CTRL     = 5'h0C;
    localparam logic [4:0] OFF_BAUD     = 5'h10;
    localparam logic [4:0] OFF_INT_EN   = 5'h14;
    localparam logic [4:0] OFF_INT_PEND = 5'h18;

    localparam int STAT_TX_FULL  = 0;
    localparam int STAT_RX_EMPTY = 1;
    localparam int STAT_RX_ERROR = 2;
    localparam int STAT_CH_EN    = 3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_PAR_LSB = 1;

    localparam int INT_RX_AVAIL = 0;
    localparam int INT_TX_SPACE = 1;
    localparam int INT_RX_ERR   = 2;
    localparam int INT_TX_OVF   = 3;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_t;

    function automatic logic offset_valid(input logic [4:0] off);
        case (off)
            OFF_TXDATA, OFF_RXDATA, OFF_STATUS, OFF_CTRL,
            OFF_BAUD, OFF_INT_EN, OFF_INT_PEND: offset_valid = 1'b1;
            default:                            offset_valid = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/apb_uart_mc_if.sv
// APB3/APB4 bus bundle between the interconnect (master) and the UART
// front-end (slave).
//   PADDR/PPROT/PSEL/PENABLE/PWRITE/PWDATA/PSTRB : master -> slave
//   PRDATA/PREADY/PSLVERR                        : slave -> master
interface apb_uart_mc_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic [2:0]              PPROT;
    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [DATA_WIDTH-1:0]   PWDATA;
    logic [DATA_WIDTH/8-1:0] PSTRB;
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport master (
        output PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/uart_apb_ch_regs.sv
// Per-channel configuration and interrupt state for one UART channel.
//   clk, rst_n              : clock, async active-low reset
//   wr_ctrl/baud/int_en/int_pend : one-cycle write strobes from the bus side
//   wdata, strb             : captured write data and byte strobes
//   tx_ovf                  : TX write dropped after timeout
//   tx_full/rx_empty/rx_error : FIFO flags from the UART core
//   ch_en, parity_mode, baud_div, int_en, int_pend : register contents
//   irq_term                : OR of enabled pending bits for this channel
module uart_apb_ch_regs
    import uart_apb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DIV_WIDTH   = 16,
    parameter int DEFAULT_DIV = 27
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_ctrl,
    input  logic                    wr_baud,
    input  logic                    wr_int_en,
    input  logic                    wr_int_pend,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] strb,
    input  logic                    tx_ovf,
    input  logic                    tx_full,
    input  logic                    rx_empty,
    input  logic                    rx_error,
    output logic                    ch_en,
    output logic [1:0]              parity_mode,
    output logic [DIV_WIDTH-1:0]    baud_div,
    output logic [3:0]              int_en,
    output logic [3:0]              int_pend,
    output logic                    irq_term
);
    logic       tx_full_q, rx_empty_q, rx_error_q;
    logic [3:0] pend_set, pend_clr;
    logic       unused_in;

    assign unused_in = ^{wdata, strb};

    always_comb begin
        pend_set               = '0;
        pend_set[INT_RX_AVAIL] = rx_empty_q & ~rx_empty;
        pend_set[INT_TX_SPACE] = tx_full_q & ~tx_full;
        pend_set[INT_RX_ERR]   = ~rx_error_q & rx_error;
        pend_set[INT_TX_OVF]   = tx_ovf;
        pend_clr = (wr_int_pend && strb[0]) ? wdata[3:0] : 4'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_full_q   <= 1'b0;
            rx_empty_q  <= 1'b1;
            rx_error_q  <= 1'b0;
            ch_en       <= 1'b0;
            parity_mode <= PAR_NONE;
            baud_div    <= DIV_WIDTH'(DEFAULT_DIV);
            int_en      <= '0;
            int_pend    <= '0;
        end else begin
            tx_full_q  <= tx_full;
            rx_empty_q <= rx_empty;
            rx_error_q <= rx_error;
            if (wr_ctrl && strb[0]) begin
                ch_en       <= wdata[CTRL_EN];
                parity_mode <= wdata[CTRL_PAR_LSB +: 2];
            end
            for (int i = 0; i < DIV_WIDTH; i++) begin
                if (wr_baud && strb[i/8]) baud_div[i] <= wdata[i];
            end
            if (wr_int_en && strb[0]) int_en <= wdata[3:0];
            // a new event in the same cycle as its W1C keeps the bit set
            int_pend <= (int_pend & ~pend_clr) | pend_set;
        end
    end

    assign irq_term = |(int_pend & int_en);

endmodule

// File: rtl/apb_uart_mc.sv
// APB slave front-end for NUM_CH UART channels.
//   PCLK, PRESETn : clock, async active-low reset
//   apb           : APB slave bundle
//   tx_wr_en/tx_din, tx_full           : per-channel TX FIFO push side
//   rx_rd_en, rx_dout/rx_empty/rx_error : per-channel RX FIFO pop side (FWFT)
//   ch_en/parity_mode/baud_div          : per-channel UART configuration
//   irq                                 : registered merged interrupt
//
// state     | meaning
// ST_IDLE   | no transfer in progress, waiting for a setup phase
// ST_ACCESS | access phase, PREADY held low while the selected FIFO blocks
module apb_uart_mc
    import uart_apb_pkg::*;
#(
    parameter int NUM_CH       = 2,
    parameter int DATA_BITS    = 8,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int DIV_WIDTH    = 16,
    parameter int DEFAULT_DIV  = 27,
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    apb_uart_mc_if.slave                  apb,
    output logic [NUM_CH-1:0]             tx_wr_en,
    output logic [NUM_CH*DATA_BITS-1:0]   tx_din,
    input  logic [NUM_CH-1:0]             tx_full,
    output logic [NUM_CH-1:0]             rx_rd_en,
    input  logic [NUM_CH*DATA_BITS-1:0]   rx_dout,
    input  logic [NUM_CH-1:0]             rx_empty,
    input  logic [NUM_CH-1:0]             rx_error,
    output logic [NUM_CH-1:0]             ch_en,
    output logic [2*NUM_CH-1:0]           parity_mode,
    output logic [NUM_CH*DIV_WIDTH-1:0]   baud_div,
    output logic                          irq
);
    localparam int WCNT_W = $clog2(WAIT_TIMEOUT + 1);

    state_t                  state_q, state_d;
    logic [7:0]              addr_q;
    logic                    write_q, priv_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] strb_q;
    logic [WCNT_W-1:0]       wait_cnt_q;
    logic                    irq_q;

    logic [2:0]              ch;
    logic [4:0]              off;
    logic                    setup, ch_ok, dec_err, prot_err, is_tx, is_rx;
    logic                    blocked, timeout, pready, slverr_int, done_ok;
    logic                    tx_full_sel, rx_empty_sel, rx_error_sel, ch_en_sel;
    logic [DATA_BITS-1:0]    rx_dout_sel;
    logic [1:0]              par_sel;
    logic [DIV_WIDTH-1:0]    baud_sel;
    logic [3:0]              int_en_sel, int_pend_sel;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [3:0]              int_en_a   [NUM_CH];
    logic [3:0]              int_pend_a [NUM_CH];
    logic [NUM_CH-1:0]       irq_term;
    logic                    unused_apb;

    assign unused_apb = ^{apb.PADDR, apb.PPROT};
    assign setup      = (state_q == ST_IDLE) && apb.PSEL && !apb.PENABLE;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            write_q    <= 1'b0;
            priv_q     <= 1'b0;
            wdata_q    <= '0;
            strb_q     <= '0;
            wait_cnt_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= |irq_term;
            if (setup) begin
                addr_q     <= apb.PADDR[7:0];
                write_q    <= apb.PWRITE;
                priv_q     <= apb.PPROT[0];
                wdata_q    <= apb.PWDATA;
                strb_q     <= apb.PSTRB;
                wait_cnt_q <= '0;
            end else if (state_q == ST_ACCESS && !pready) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (setup)  state_d = ST_ACCESS;
            ST_ACCESS: if (pready) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ch           = addr_q[7:5];
        off          = addr_q[4:0];
        ch_ok        = 1'b0;
        tx_full_sel  = 1'b0;
        rx_empty_sel = 1'b0;
        rx_error_sel = 1'b0;
        rx_dout_sel  = '0;
        ch_en_sel    = 1'b0;
        par_sel      = '0;
        baud_sel     = '0;
        int_en_sel   = '0;
        int_pend_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch == 3'(c)) begin
                ch_ok        = 1'b1;
                tx_full_sel  = tx_full[c];
                rx_empty_sel = rx_empty[c];
                rx_error_sel = rx_error[c];
                rx_dout_sel  = rx_dout[c*DATA_BITS +: DATA_BITS];
                ch_en_sel    = ch_en[c];
                par_sel      = parity_mode[2*c +: 2];
                baud_sel     = baud_div[c*DIV_WIDTH +: DIV_WIDTH];
                int_en_sel   = int_en_a[c];
                int_pend_sel = int_pend_a[c];
            end
        end
        dec_err  = !(ch_ok && offset_valid(off));
        prot_err = !dec_err && write_q && !priv_q && (off == OFF_CTRL || off == OFF_BAUD);
        // TXDATA without byte 0 is a no-op and must not wait on a full FIFO
        is_tx    = !dec_err && write_q && (off == OFF_TXDATA) && strb_q[0];
        is_rx    = !dec_err && !write_q && (off == OFF_RXDATA);
        blocked  = (is_tx && tx_full_sel) || (is_rx && rx_empty_sel);
        timeout  = (wait_cnt_q == WCNT_W'(WAIT_TIMEOUT));
        pready   = (state_q == ST_ACCESS) && (!blocked || timeout);
        // still blocked at completion can only mean the timeout expired
        slverr_int = dec_err || prot_err || blocked;
        done_ok    = pready && !slverr_int;

        rdata = '0;
        case (off)
            OFF_RXDATA: rdata[DATA_BITS-1:0] = rx_dout_sel;
            OFF_STATUS: begin
                rdata[STAT_TX_FULL]  = tx_full_sel;
                rdata[STAT_RX_EMPTY] = rx_empty_sel;
                rdata[STAT_RX_ERROR] = rx_error_sel;
                rdata[STAT_CH_EN]    = ch_en_sel;
            end
            OFF_CTRL: begin
                rdata[CTRL_EN]           = ch_en_sel;
                rdata[CTRL_PAR_LSB +: 2] = par_sel;
            end
            OFF_BAUD:     rdata[DIV_WIDTH-1:0] = baud_sel;
            OFF_INT_EN:   rdata[3:0]           = int_en_sel;
            OFF_INT_PEND: rdata[3:0]           = int_pend_sel;
            default:      rdata                = '0;
        endcase
    end

    assign apb.PREADY  = pready;
    assign apb.PSLVERR = pready && slverr_int;
    assign apb.PRDATA  = done_ok ? rdata : '0;
    assign irq         = irq_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic sel, wr_hit;
        assign sel    = (ch == 3'(c));
        assign wr_hit = done_ok && write_q && sel;

        assign tx_wr_en[c] = done_ok && is_tx && sel;
        assign rx_rd_en[c] = done_ok && is_rx && sel;
        assign tx_din[c*DATA_BITS +: DATA_BITS] = wdata_q[DATA_BITS-1:0];

        uart_apb_ch_regs #(
            .DATA_WIDTH  (DATA_WIDTH),
            .DIV_WIDTH   (DIV_WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_regs (
            .clk         (PCLK),
            .rst_n       (PRESETn),
            .wr_ctrl     (wr_hit && off == OFF_CTRL),
            .wr_baud     (wr_hit && off == OFF_BAUD),
            .wr_int_en   (wr_hit && off == OFF_INT_EN),
            .wr_int_pend (wr_hit && off == OFF_INT_PEND),
            .wdata       (wdata_q),
            .strb        (strb_q),
            .tx_ovf      (pready && is_tx && blocked && sel),
            .tx_full     (tx_full[c]),
            .rx_empty    (rx_empty[c]),
            .rx_error    (rx_error[c]),
            .ch_en       (ch_en[c]),
            .parity_mode (parity_mode[2*c +: 2]),
            .baud_div    (baud_div[c*DIV_WIDTH +: DIV_WIDTH]),
            .int_en      (int_en_a[c]),
            .int_pend    (int_pend_a[c]),
            .irq_term    (irq_term[c])
        );
    end

endmodule
